// File: rtl/cpu_types_pkg.sv
// Shared CPU-side types: machine word, data-cache address split, MSI
// coherence state and the snoop responder's FSM encoding.
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    // Data cache geometry: direct-mapped, two words per block.
    localparam int DC_SETS = 8;
    localparam int DC_IW   = $clog2(DC_SETS);
    localparam int DC_TAGW = 32 - DC_IW - 3;

    typedef enum logic [1:0] {
        I = 2'b00,
        S = 2'b01,
        M = 2'b10
    } msi_t;

    typedef struct packed {
        logic [DC_TAGW-1:0] tag;
        logic [DC_IW-1:0]   idx;
        logic               blkoff;
        logic [1:0]         bytoff;
    } dcache_addr_t;

    typedef enum logic [1:0] {
        SN_IDLE = 2'b00,
        SN_WB0  = 2'b01,
        SN_WB1  = 2'b10
    } snoop_state_t;

endpackage

// File: rtl/snoop_responder.sv
// Cache-side coherence agent: answers controller snoops against the dcache
// tag/MSI table, writes back Modified blocks word by word and downgrades or
// invalidates the snooped set. The table is also the dcache's own tag store.
module snoop_responder
    import cpu_types_pkg::*;
#(
    parameter int SETS = DC_SETS,
    parameter int IW   = $clog2(SETS),
    parameter int TW   = 32 - IW - 3
) (
    input  logic          CLK,
    input  logic          nRST,
    input  logic          ccwait,
    input  logic          ccinv,
    input  logic [31:0]   ccsnoopaddr,
    input  logic          dwait,
    output logic          dWEN,
    output logic [31:0]   daddr,
    output logic [31:0]   dstore,
    output logic          snoop_busy,
    output logic [IW-1:0] rd_idx,
    input  logic [31:0]   rd_data0,
    input  logic [31:0]   rd_data1,
    input  logic [IW-1:0] lk_idx,
    output logic [TW-1:0] lk_tag,
    output logic [1:0]    lk_state,
    input  logic          upd_en,
    input  logic [IW-1:0] upd_idx,
    input  logic [TW-1:0] upd_tag,
    input  logic [1:0]    upd_state
);

    snoop_state_t  state_reg, state_next;
    logic          inv_reg;
    logic [IW-1:0] idx_reg;
    logic [TW-1:0] tag_reg;

    logic [TW-1:0] tag_tbl   [SETS];
    msi_t          state_tbl [SETS];

    // Snooped address split; the low three bits are irrelevant to a lookup.
    logic [TW-1:0] snp_tag;
    logic [IW-1:0] snp_idx;
    logic          unused_bits;
    assign snp_tag     = ccsnoopaddr[31:IW+3];
    assign snp_idx     = ccsnoopaddr[IW+2:3];
    assign unused_bits = ^ccsnoopaddr[2:0];

    logic snp_hit, snp_start_wb, snp_s_inv, wb_commit;
    assign snp_hit      = (tag_tbl[snp_idx] == snp_tag) && (state_tbl[snp_idx] != I);
    assign snp_start_wb = (state_reg == SN_IDLE) && ccwait && snp_hit && (state_tbl[snp_idx] == M);
    assign snp_s_inv    = (state_reg == SN_IDLE) && ccwait && snp_hit && (state_tbl[snp_idx] == S) && ccinv;
    assign wb_commit    = (state_reg == SN_WB1) && !dwait;

    // FSM state and latched snoop context.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_reg <= SN_IDLE;
            inv_reg   <= 1'b0;
            idx_reg   <= '0;
            tag_reg   <= '0;
        end else begin
            state_reg <= state_next;
            if (snp_start_wb) begin
                inv_reg <= ccinv;
                idx_reg <= snp_idx;
                tag_reg <= snp_tag;
            end
        end
    end

    // Next state: each writeback word advances only when the controller accepts it.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            SN_IDLE: if (snp_start_wb) state_next = SN_WB0;
            SN_WB0:  if (!dwait)       state_next = SN_WB1;
            SN_WB1:  if (!dwait)       state_next = SN_IDLE;
            default:                   state_next = SN_IDLE;
        endcase
    end

    // Bus outputs: dWEN held through both words so the controller sees one phase.
    always_comb begin
        dWEN   = 1'b0;
        daddr  = '0;
        dstore = '0;
        case (state_reg)
            SN_WB0: begin
                dWEN   = 1'b1;
                daddr  = {tag_reg, idx_reg, 1'b0, 2'b00};
                dstore = rd_data0;
            end
            SN_WB1: begin
                dWEN   = 1'b1;
                daddr  = {tag_reg, idx_reg, 1'b1, 2'b00};
                dstore = rd_data1;
            end
            default: ;
        endcase
    end

    assign snoop_busy = ccwait || (state_reg != SN_IDLE);
    assign rd_idx     = (state_reg == SN_IDLE) ? snp_idx : idx_reg;
    assign lk_tag     = tag_tbl[lk_idx];
    assign lk_state   = state_tbl[lk_idx];

    // Per-set table entries; a snoop state change beats a dcache update.
    generate
        for (genvar gi = 0; gi < SETS; gi++) begin : g_set
            logic sel_commit, sel_sinv, sel_upd;
            assign sel_commit = wb_commit && (idx_reg == IW'(gi));
            assign sel_sinv   = snp_s_inv && (snp_idx == IW'(gi));
            assign sel_upd    = upd_en && (upd_idx == IW'(gi));

            // Entry register for set gi.
            always_ff @(posedge CLK or negedge nRST) begin
                if (!nRST) begin
                    tag_tbl[gi]   <= '0;
                    state_tbl[gi] <= I;
                end else if (sel_commit) begin
                    state_tbl[gi] <= inv_reg ? I : S;
                end else if (sel_sinv) begin
                    state_tbl[gi] <= I;
                end else if (sel_upd) begin
                    tag_tbl[gi]   <= upd_tag;
                    state_tbl[gi] <= msi_t'(upd_state);
                end
            end
        end
    endgenerate

endmodule

// File: tb/tb_snoop_responder.sv
// Scoreboard bench for snoop_responder: directed snoops push expected
// writeback words, a bus-model monitor pops and compares on each accept.
module tb_snoop_responder;
    import cpu_types_pkg::*;

    localparam int IW = 3;
    localparam int TW = 26;

    logic          CLK = 1'b0;
    logic          nRST = 1'b0;
    logic          ccwait = 1'b0, ccinv = 1'b0;
    logic [31:0]   ccsnoopaddr = '0;
    logic          dwait = 1'b0;
    logic          dWEN;
    logic [31:0]   daddr, dstore;
    logic          snoop_busy;
    logic [IW-1:0] rd_idx;
    logic [31:0]   rd_data0, rd_data1;
    logic [IW-1:0] lk_idx = '0;
    logic [TW-1:0] lk_tag;
    logic [1:0]    lk_state;
    logic          upd_en = 1'b0;
    logic [IW-1:0] upd_idx = '0;
    logic [TW-1:0] upd_tag = '0;
    logic [1:0]    upd_state = 2'b00;

    logic [31:0] mem0 [8];
    logic [31:0] mem1 [8];
    assign rd_data0 = mem0[rd_idx];
    assign rd_data1 = mem1[rd_idx];

    snoop_responder dut (
        .CLK(CLK), .nRST(nRST), .ccwait(ccwait), .ccinv(ccinv),
        .ccsnoopaddr(ccsnoopaddr), .dwait(dwait), .dWEN(dWEN),
        .daddr(daddr), .dstore(dstore), .snoop_busy(snoop_busy),
        .rd_idx(rd_idx), .rd_data0(rd_data0), .rd_data1(rd_data1),
        .lk_idx(lk_idx), .lk_tag(lk_tag), .lk_state(lk_state),
        .upd_en(upd_en), .upd_idx(upd_idx), .upd_tag(upd_tag),
        .upd_state(upd_state)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;
    int hold_cfg = 0;
    int wcnt = 0;
    int dwen_cnt = 0;
    logic [63:0] exp_q [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end else begin
            $display("ok   %s: 0x%08h", name, act);
        end
    endtask

    // Bus model and monitor: inserts hold_cfg wait cycles per word, compares accepted words.
    always @(negedge CLK) begin
        if (dWEN) begin
            dwen_cnt++;
            if (wcnt < hold_cfg) begin
                dwait = 1'b1;
                wcnt++;
            end else begin
                dwait = 1'b0;
                wcnt  = 0;
                if (exp_q.size() == 0) begin
                    chk("unexpected_wb_word", daddr, 32'hFFFF_FFFF);
                end else begin
                    logic [63:0] e;
                    e = exp_q.pop_front();
                    chk("wb_daddr", daddr, e[63:32]);
                    chk("wb_dstore", dstore, e[31:0]);
                end
            end
        end else begin
            dwait = 1'b0;
            wcnt  = 0;
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic upd(input int idx, input int tag, input logic [1:0] st);
        tick();
        upd_en = 1'b1; upd_idx = IW'(idx); upd_tag = TW'(tag); upd_state = st;
        tick();
        upd_en = 1'b0;
    endtask

    task automatic lk(input string name, input int idx, input logic [1:0] st, input int tag);
        lk_idx = IW'(idx);
        #1;
        chk({name, "_state"}, 32'(lk_state), 32'(st));
        chk({name, "_tag"}, 32'(lk_tag), 32'(tag));
    endtask

    // Modified-block snoop: pushes both expected words, waits out the writeback.
    task automatic wb_snoop(input logic [31:0] addr, input logic inv, input int hold, input int exp_cycles);
        int first;
        bit seen;
        int idx;
        hold_cfg = hold;
        idx = int'(addr[5:3]);
        exp_q.push_back({addr & 32'hFFFF_FFF8, mem0[idx]});
        exp_q.push_back({(addr & 32'hFFFF_FFF8) | 32'h4, mem1[idx]});
        tick();
        dwen_cnt = 0;
        ccsnoopaddr = addr; ccinv = inv; ccwait = 1'b1;
        first = -1; seen = 0;
        for (int k = 0; k < 100; k++) begin
            @(negedge CLK);
            if (dWEN) begin
                if (!seen) first = k;
                seen = 1;
            end else if (seen) begin
                break;
            end
        end
        chk("dwen_rise_latency", 32'(first), 32'd1);
        tick();
        ccwait = 1'b0;
        repeat (2) tick();
        chk("dwen_cycles", 32'(dwen_cnt), 32'(exp_cycles));
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    endtask

    // Non-writeback snoop: one ccwait cycle, must never raise dWEN.
    task automatic quiet_snoop(input string name, input logic [31:0] addr, input logic inv);
        tick();
        dwen_cnt = 0;
        ccsnoopaddr = addr; ccinv = inv; ccwait = 1'b1;
        #1;
        chk({name, "_busy_hi"}, 32'(snoop_busy), 32'd1);
        tick();
        ccwait = 1'b0;
        #1;
        chk({name, "_busy_lo"}, 32'(snoop_busy), 32'd0);
        repeat (2) tick();
        chk({name, "_no_dwen"}, 32'(dwen_cnt), 32'd0);
    endtask

    initial begin
        for (int i = 0; i < 8; i++) begin
            mem0[i] = 32'h1000_0000 + 32'(i);
            mem1[i] = 32'h2000_0000 + 32'(i);
        end
        mem0[3] = 32'hAAAA_0000;
        mem1[3] = 32'hBBBB_0000;

        // Reset state.
        repeat (2) tick();
        for (int i = 0; i < 8; i++) lk($sformatf("reset_set%0d", i), i, I, 0);
        chk("reset_dwen", 32'(dWEN), 32'd0);
        nRST = 1'b1;
        tick();
        chk("idle_daddr", daddr, 32'd0);

        // M hit, no invalidate, no wait states -> downgrade to S.
        upd(3, 1, M);
        lk("set3_before", 3, M, 1);
        wb_snoop(32'h0000_0058, 1'b0, 0, 2);
        lk("set3_after_wb", 3, S, 1);

        // M hit with invalidate, three wait cycles per word -> I.
        upd(3, 1, M);
        wb_snoop(32'h0000_0058, 1'b1, 3, 8);
        lk("set3_after_inv_wb", 3, I, 1);

        // S hit: no invalidate keeps S, invalidate drops to I.
        upd(5, 1, S);
        quiet_snoop("s_keep", 32'h0000_0068, 1'b0);
        lk("set5_keep", 5, S, 1);
        quiet_snoop("s_inv", 32'h0000_0068, 1'b1);
        lk("set5_inv", 5, I, 1);

        // Tag miss on an M set.
        upd(6, 2, M);
        quiet_snoop("miss", 32'h0000_0070, 1'b1);
        lk("set6_miss", 6, M, 2);

        // Reset asserted during the second writeback word.
        upd(3, 1, M);
        hold_cfg = 3;
        exp_q.push_back({32'h0000_0058, mem0[3]});
        tick();
        ccsnoopaddr = 32'h0000_0058; ccinv = 1'b0; ccwait = 1'b1;
        begin
            bit reached;
            reached = 0;
            for (int k = 0; k < 40; k++) begin
                @(negedge CLK);
                if (dWEN && daddr == 32'h0000_005C) begin
                    reached = 1;
                    break;
                end
            end
            chk("reached_wb1", 32'(reached), 32'd1);
        end
        #1;
        nRST = 1'b0;
        #1;
        chk("rst_dwen_drop", 32'(dWEN), 32'd0);
        chk("rst_daddr", daddr, 32'd0);
        chk("rst_queue_used", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
        ccwait = 1'b0;
        tick();
        for (int i = 0; i < 8; i++) lk($sformatf("rst_mid_set%0d", i), i, I, 0);
        nRST = 1'b1;
        repeat (2) tick();
        chk("post_rst_dwen", 32'(dWEN), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Global watchdog.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
